// File: rtl/block_reader.sv
// Streams words 0..len-1 out of a synchronous-read product memory into a small
// output FIFO, then to a consumer over a valid/acknowledge handshake.
module block_reader #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN_blockRead,
  input  logic [ADDR_W:0]   write_count,
  output logic              RDY_blockRead,
  output logic              EN_readMem,
  output logic [ADDR_W-1:0] readMem_addr,
  input  logic [DATA_W-1:0] readMem_val,
  output logic              VALID_memVal,
  output logic [DATA_W-1:0] memVal_data,
  input  logic              ACK_memVal,
  output logic              DONE_blockRead,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a word moves on any rising edge where VALID_memVal and
  // ACK_memVal are both high; the head word holds steady until then.

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(BUF_DEPTH);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PW-1:0]   LAST_P  = PW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     nxt_q, nxt_d;
  logic                en_q, en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rv_q;
  logic                done_q, done_d;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [DATA_W-1:0]   fifo_mem [BUF_DEPTH];

  logic                push, pop, room;
  logic [ADDR_W:0]     wc_clamped;

  // rv_q marks the cycle in which readMem_val carries the word issued last cycle.
  assign push = rv_q;
  assign pop  = VALID_memVal & ACK_memVal;

  assign count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  // After this edge the FIFO plus reads in flight must still leave a slot for a new read.
  assign room    = ({1'b0, count_d} + {{CW{1'b0}}, en_q}) < DEPTH_C;

  assign wc_clamped = (write_count > MAX_LEN) ? MAX_LEN : write_count;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    nxt_d   = nxt_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (EN_blockRead) begin
          if (write_count == '0) begin
            done_d = 1'b1;
          end else begin
            // The FIFO is empty in IDLE, so address 0 can go out on the start edge.
            len_d   = wc_clamped;
            en_d    = 1'b1;
            addr_d  = '0;
            nxt_d   = (ADDR_W + 1)'(1);
            state_d = (wc_clamped == (ADDR_W + 1)'(1)) ? DRAIN : READ;
          end
        end
      end
      READ: begin
        if (room) begin
          en_d   = 1'b1;
          addr_d = nxt_q[ADDR_W-1:0];
          nxt_d  = nxt_q + 1'b1;
          if (nxt_q == len_q - 1'b1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!en_q && !rv_q && count_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      nxt_q   <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      rv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      nxt_q   <= nxt_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      rv_q    <= en_q;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= readMem_val;
  end

  assign RDY_blockRead  = (state_q == IDLE);
  assign EN_readMem     = en_q;
  assign readMem_addr   = addr_q;
  assign VALID_memVal   = (count_q != '0);
  assign memVal_data    = VALID_memVal ? fifo_mem[rd_ptr_q] : '0;
  assign DONE_blockRead = done_q;
  assign dbg_state_o    = state_q;

endmodule
